frame_ram_arbiter: RTL
======================

# frame_ram_arbiter

Shares the single-port 24-bit × 64K `frame_ram` between two requesters:
- the display scan engine, which reads pixel words;
- the frame writer, which pushes pixel updates.

The block sits between those two clients and the `frame_ram` instance in `led_display`. It owns every RAM control pin. Reads win by default, and an optional fairness counter stops writes from being starved during a continuous scan.

## Interface
Parameters:
- `RD_LATENCY`, 1 — RAM read latency in cycles from registered `ram_enable_out` to valid `ram_data_in`; legal values 1..2.
- `FRAME_WORDS`, 2048 — number of valid pixel addresses (64×32).
- `MAX_RD_RUN`, 8 — maximum consecutive read grants while a write is pending; used only when fairness is enabled.

Ports:
- `clk_in` in 1 — system clock (100 MHz). One clock; all logic is on this clock.
- `reset_in` in 1 — asynchronous, active-high reset.
- `rd_req_in` in 1 — read request.
- `rd_addr_in` in 16 — read address.
- `rd_ack_out` out 1 — read request accepted this cycle.
- `rd_valid_out` out 1 — `rd_data_out` valid (one-cycle pulse).
- `rd_data_out` out 24 — read data.
- `wr_req_in` in 1 — write request.
- `wr_addr_in` in 16 — write address.
- `wr_data_in` in 24 — write data.
- `wr_ack_out` out 1 — write request accepted this cycle.
- `ram_enable_out` out 1 — RAM enable.
- `ram_write_enable_out` out 1 — RAM write enable.
- `ram_addr_out` out 16 — RAM address.
- `ram_data_out` out 24 — RAM write data.
- `ram_data_in` in 24 — RAM read data.
- `addr_err_out` out 1 — sticky flag: an out-of-range request was seen.

## Operation
- **Handshake:** valid/ready per port.
  - A requester holds `*_req_in` and its address/data stable until it sees `*_ack_out` high in the same cycle.
  - A transfer occurs on the rising edge where req and ack are both high.
- **Acks:**
  - `rd_ack_out` and `wr_ack_out` are combinational from the requests and the registered fairness state.
  - At most one ack is high per cycle.
  - One transfer is accepted per cycle.
- **Grant rule when fairness is disabled:**
  - `rd_req_in` alone: grant read.
  - `wr_req_in` alone: grant write.
  - Both: grant read.
- **Grant rule when fairness is enabled:**
  - A `run_cnt` counter (0..`MAX_RD_RUN`) counts consecutive read grants made while `wr_req_in` was high.
  - When both requests are high and `run_cnt == MAX_RD_RUN`, grant write and clear `run_cnt`.
  - `run_cnt` also clears on any cycle where `wr_req_in` is low.
- **Range check:** address ≥ `FRAME_WORDS` is out of range.
  - The request is still acked.
  - `ram_enable_out` stays 0 for it.
  - `addr_err_out` sets and holds until reset.
  - An out-of-range read still returns `rd_valid_out` at normal latency, with `rd_data_out = 0`.
- **Read return pipeline:** a shift register of depth `RD_LATENCY+1` carries the valid bit and the out-of-range bit. It tracks reads issued back to back with no bubbles.
- **Idle:** no grant means `ram_enable_out = 0` and `ram_write_enable_out = 0`. Address and data outputs hold their last values.

## Timing
- **Cycle N:** request acked.
- **Cycle N+1:** `ram_*_out` registered and driving the RAM.
- **Reads:** RAM data is valid at N+1+`RD_LATENCY`. It is registered, so `rd_valid_out`/`rd_data_out` appear at N+2+`RD_LATENCY`. Default total latency is 3 cycles.
- **Writes:** committed to RAM at the edge ending cycle N+1.
- **Throughput:** back-to-back reads give one `rd_valid_out` per cycle.
- **Mixed traffic:** a read followed immediately by a write to the same address returns the old data, because RAM accesses happen in strict accept order.
- **Reset** (asynchronous, any time, including mid-read):
  - all outputs go to 0: `ram_enable_out`, `ram_write_enable_out`, `ram_addr_out`, `ram_data_out`, `rd_valid_out`, `rd_data_out`, `addr_err_out`;
  - `run_cnt` clears and the return pipeline flushes;
  - in-flight reads produce no `rd_valid_out` after reset is released;
  - acks are 0 while `reset_in` is high.

## Configuration
- Macro `FRAME_RAM_ARB_FAIRNESS_EN`.
  - **Defined:** the `run_cnt` fairness counter and `MAX_RD_RUN` behaviour are compiled in.
  - **Undefined:** strict read priority; no counter logic; `MAX_RD_RUN` is ignored.

## Test plan
- **Single read:** RAM preloaded addr 5 = 0xA1B2C3; read req addr 5 at cycle N.
  - `rd_ack_out` is high at N; `ram_enable_out = 1` and `ram_write_enable_out = 0` at N+1; `rd_valid_out = 1` with data 0xA1B2C3 at N+3.
- **Write then readback:** write 0x123456 to addr 100, then read addr 100.
  - The read returns 0x123456.
  - Back-to-back reads of addr 0..15 give 16 consecutive `rd_valid_out` pulses, in order.
- **Contention, fairness undefined:** both requests held high for 20 cycles.
  - 20 read acks and 0 write acks.
- **Contention, fairness defined, `MAX_RD_RUN` = 8:** both requests held high.
  - Grant sequence is 8 reads, 1 write, repeating.
  - Dropping `wr_req_in` for one cycle restarts the count at 0.
- **Out of range:** read addr 2048.
  - Ack is given; `ram_enable_out` stays 0; `rd_data_out = 0` with `rd_valid_out` at N+3; `addr_err_out` goes to 1 and stays 1.
- **Reset mid-operation:** assert `reset_in` one cycle after a read ack.
  - All outputs go to 0 immediately (asynchronously).
  - No `rd_valid_out` after release.
  - The next read completes normally.

Source files
------------

// File: rtl/frame_ram_arbiter_if.sv
// Client handshakes and frame_ram control pins of frame_ram_arbiter.
// slave: the arbiter's view; master: clients plus the RAM.
interface frame_ram_arbiter_if;
    logic        rd_req_in;
    logic [15:0] rd_addr_in;
    logic        rd_ack_out;
    logic        rd_valid_out;
    logic [23:0] rd_data_out;
    logic        wr_req_in;
    logic [15:0] wr_addr_in;
    logic [23:0] wr_data_in;
    logic        wr_ack_out;
    logic        ram_enable_out;
    logic        ram_write_enable_out;
    logic [15:0] ram_addr_out;
    logic [23:0] ram_data_out;
    logic [23:0] ram_data_in;
    logic        addr_err_out;

    modport slave (
        input  rd_req_in, rd_addr_in, wr_req_in, wr_addr_in, wr_data_in, ram_data_in,
        output rd_ack_out, rd_valid_out, rd_data_out, wr_ack_out, ram_enable_out,
               ram_write_enable_out, ram_addr_out, ram_data_out, addr_err_out
    );

    modport master (
        output rd_req_in, rd_addr_in, wr_req_in, wr_addr_in, wr_data_in, ram_data_in,
        input  rd_ack_out, rd_valid_out, rd_data_out, wr_ack_out, ram_enable_out,
               ram_write_enable_out, ram_addr_out, ram_data_out, addr_err_out
    );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Read-priority arbiter sharing the single-port frame_ram between scan reads and frame writes.
// Define FRAME_RAM_ARB_FAIRNESS_EN to force a write after MAX_RD_RUN reads while one is pending.
module frame_ram_arbiter #(
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned FRAME_WORDS = 2048,
    parameter int unsigned MAX_RD_RUN  = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    frame_ram_arbiter_if.slave bus
);
    localparam int unsigned PipeDepth = RD_LATENCY + 1;

    if (RD_LATENCY < 1 || RD_LATENCY > 2 || MAX_RD_RUN < 1) begin : g_bad_param
        $error("frame_ram_arbiter: RD_LATENCY must be 1..2 and MAX_RD_RUN at least 1");
    end

    logic                 rd_oor, wr_oor;
    logic                 rd_grant, wr_grant;
    logic                 wr_turn;
    logic                 ram_en_q, ram_we_q;
    logic [15:0]          ram_addr_q;
    logic [23:0]          ram_wdata_q;
    logic [PipeDepth-1:0] pipe_vld_q, pipe_oor_q;
    logic                 rd_valid_q;
    logic [23:0]          rd_data_q;
    logic                 addr_err_q;

    assign rd_oor = 32'(bus.rd_addr_in) >= FRAME_WORDS;
    assign wr_oor = 32'(bus.wr_addr_in) >= FRAME_WORDS;

`ifdef FRAME_RAM_ARB_FAIRNESS_EN
    localparam int unsigned CntW = $clog2(MAX_RD_RUN + 1);

    logic [CntW-1:0] run_cnt_q, run_cnt_d;

    assign wr_turn = 32'(run_cnt_q) == MAX_RD_RUN;

    // Counts reads granted while a write waits; any gap in the write request restarts it.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!bus.wr_req_in || wr_grant) begin
            run_cnt_d = '0;
        end else if (rd_grant) begin
            run_cnt_d = run_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end
`else
    assign wr_turn = 1'b0;
`endif

    assign rd_grant = !reset_in && bus.rd_req_in && !(bus.wr_req_in && wr_turn);
    assign wr_grant = !reset_in && bus.wr_req_in && !rd_grant;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            pipe_vld_q  <= '0;
            pipe_oor_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            ram_en_q <= (rd_grant && !rd_oor) || (wr_grant && !wr_oor);
            ram_we_q <= wr_grant && !wr_oor;
            if (rd_grant && !rd_oor) begin
                ram_addr_q <= bus.rd_addr_in;
            end else if (wr_grant && !wr_oor) begin
                ram_addr_q  <= bus.wr_addr_in;
                ram_wdata_q <= bus.wr_data_in;
            end
            // Out-of-range reads ride the pipe so they return at normal latency with zero data.
            pipe_vld_q <= {pipe_vld_q[PipeDepth-2:0], rd_grant};
            pipe_oor_q <= {pipe_oor_q[PipeDepth-2:0], rd_grant && rd_oor};
            rd_valid_q <= pipe_vld_q[PipeDepth-1];
            if (pipe_vld_q[PipeDepth-1]) begin
                rd_data_q <= pipe_oor_q[PipeDepth-1] ? 24'd0 : bus.ram_data_in;
            end
            if ((rd_grant && rd_oor) || (wr_grant && wr_oor)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign bus.rd_ack_out           = rd_grant;
    assign bus.wr_ack_out           = wr_grant;
    assign bus.ram_enable_out       = ram_en_q;
    assign bus.ram_write_enable_out = ram_we_q;
    assign bus.ram_addr_out         = ram_addr_q;
    assign bus.ram_data_out         = ram_wdata_q;
    assign bus.rd_valid_out         = rd_valid_q;
    assign bus.rd_data_out          = rd_data_q;
    assign bus.addr_err_out         = addr_err_q;
endmodule
